mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit between the EX/MEM pipeline register and the word-addressed data memory. It converts word, halfword and byte loads and stores into word accesses. Subword loads are extracted and extended. Subword stores become a two-cycle read-modify-write. It stalls the pipeline while a multi-cycle access is in flight.

## Interface
Parameters:
- ADDR_W, default 32: byte-address width.
- DATA_W, default 32: word width; fixed at 32 for lane logic.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present from EX/MEM.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_op  in  3  operation code (package enum).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned for subword ops.
- stall  out  1  high while busy or a request is pending, not accepted.
- load_valid  out  1  one-cycle pulse, load result valid.
- load_data  out  32  extended load result.
- misalign_err  out  1  one-cycle pulse (macro build only).
- mem_read  out  1  to data memory.
- mem_write  out  1  to data memory.
- mem_addr  out  ADDR_W  word-aligned byte address, bits[1:0]=0.
- mem_wdata  out  32  to data memory.
- mem_rdata  in  32  combinational read data from memory.

## Operation
- Ops: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
- Lanes are little-endian: byte k = addr[1:0] maps to bits [8k+7:8k]; halfword at addr[1] maps to bits [16·addr[1]+15 : 16·addr[1]].
- States:
  - IDLE: req_ready=1.
  - LOAD_RESP: result cycle.
  - STORE_MERGE: write cycle.
- IDLE, req_valid, SW:
  - Same cycle: mem_write=1, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_wdata=req_wdata.
  - Stay in IDLE.
- IDLE, req_valid, any load:
  - Same cycle: mem_read=1.
  - Capture mem_rdata, addr[1:0] and op into registers.
  - Go to LOAD_RESP.
- LOAD_RESP:
  - load_valid=1; load_data is the captured word lane, sign-extended (LH, LB) or zero-extended (LHU, LBU); LW passes the word through.
  - Go to IDLE.
- IDLE, req_valid, SH/SB:
  - Same cycle: mem_read=1.
  - Capture mem_rdata, addr, lane, data.
  - Go to STORE_MERGE.
- STORE_MERGE:
  - mem_write=1; mem_wdata is the captured word with the target lane replaced by wdata[15:0] or wdata[7:0].
  - Go to IDLE.
- stall = (state≠IDLE) | (req_valid & ~req_ready), combinational.
- mem_read and mem_write are never high together.
- req_valid=0 in IDLE: all memory strobes are 0.

## Timing
- Reset state: IDLE.
- Outputs during and after reset:
  - req_ready=1.
  - stall=0, load_valid=0, misalign_err=0.
  - mem_read=0, mem_write=0.
  - mem_addr=0, mem_wdata=0.
  - load_data=0.
  - All capture registers=0.
- Latency:
  - SW: 1 cycle, write at the accept edge.
  - Loads: result in the cycle after accept.
  - SH/SB: write on the second edge after accept.
- Throughput: SW 1 per cycle; loads and subword stores 1 per 2 cycles.
- In non-IDLE states, req_* inputs are ignored. Upstream holds the request while stall=1.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all strobes low.
  - A subword store aborted in STORE_MERGE performs no write; memory keeps the old word.
- Back-to-back: a load that follows an SW to the same word reads the new data. The write commits at the accept edge, and the load's read happens in a later cycle.
- load_data holds its last value when load_valid=0.

## Configuration
- MAU_MISALIGN_TRAP_EN defined:
  - Misaligned requests are LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]=1.
  - Such a request pulses misalign_err for 1 cycle at accept, issues no memory strobe, and stays in IDLE.
- Undefined:
  - misalign_err is tied to 0.
  - Misaligned offsets are truncated: word ops ignore addr[1:0]; halfword ops ignore addr[0].

## Structure
- Package mau_pkg:
  - op enum (3-bit) and state enum.
  - Lane-select and extension helper functions.
  - Constant WORD_BYTES=4.
- One sub-module, mau_lane_merge: combinational extract/extend for loads and insert for stores, keyed by op and addr[1:0].

## Test plan
- After reset, LW addr 0x00 with memory word 0 = 6 → load_valid at cycle+1, load_data=0x00000006; stall high exactly 1 cycle.
- Memory word at 0x14 = 0xFFFFFFFF, LB addr 0x15 → 0xFFFFFFFF; LBU addr 0x15 → 0x000000FF; LHU addr 0x16 → 0x0000FFFF.
- Word 0x11223344 at 0x20, SB data 0xAA addr 0x22 → mem_write on the 2nd edge with 0x11AA3344; then SH 0xBEEF addr 0x20 → 0x11AABEEF.
- SW 0x12345678 to 0x40, immediately LW 0x40 → load_data=0x12345678; SW alone shows stall=0.
- SB in progress, reset_n low during STORE_MERGE → no write; word is unchanged, all outputs 0, state IDLE.
- With MAU_MISALIGN_TRAP_EN, LW addr 0x41 → misalign_err pulse, mem_read=0, load_valid=0. Without the macro → reads word 0x40.

Source files
------------

// File: rtl/mau_pkg.sv
// mau_pkg: shared types and lane helpers for the memory access unit.
//   op_t         load/store operation code as driven on req_op
//   state_t      unit FSM state (also visible on the dbg_state port)
//   WORD_BYTES   bytes per memory word
//   lane helpers byte/halfword bit offsets, load extract+extend,
//                store lane insert, misalignment test
// Lanes are little-endian: byte k sits in bits [8k+7:8k].
package mau_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_LOAD_RESP   = 2'd1,
    ST_STORE_MERGE = 2'd2
  } state_t;

  function automatic logic is_load(op_t op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  // Bit offset of the addressed byte lane.
  function automatic logic [4:0] byte_lsb(logic [1:0] offset);
    return {offset, 3'b000};
  endfunction

  // Bit offset of the addressed halfword lane; offset[0] is ignored.
  function automatic logic [4:0] half_lsb(logic [1:0] offset);
    return {offset[1], 4'b0000};
  endfunction

  function automatic logic [31:0] lane_extract(op_t op, logic [1:0] offset,
                                               logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[byte_lsb(offset) +: 8];
    h = word[half_lsb(offset) +: 16];
    case (op)
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h000000, b};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_insert(op_t op, logic [1:0] offset,
                                              logic [31:0] word,
                                              logic [15:0] data);
    logic [31:0] r;
    r = word;
    case (op)
      OP_SH:   r[half_lsb(offset) +: 16] = data;
      OP_SB:   r[byte_lsb(offset) +: 8]  = data[7:0];
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(op_t op, logic [1:0] offset);
    case (op)
      OP_LW, OP_SW:         return offset != 2'b00;
      OP_LH, OP_LHU, OP_SH: return offset[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// mau_lane_merge: combinational lane logic for the memory access unit.
//   op         captured operation
//   offset     captured addr[1:0]
//   word       captured memory word
//   wdata      captured store data (right-aligned, low 16 bits)
//   load_data  extracted and sign/zero-extended load result
//   store_word word with the target lane replaced by the store data
module mau_lane_merge
  import mau_pkg::*;
(
  input  op_t         op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  assign load_data  = lane_extract(op, offset, word);
  assign store_word = lane_insert(op, offset, word, wdata);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit in front of a word-addressed
// data memory with combinational read data.
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; a request is accepted in any
//                         cycle where both are high (ready only in IDLE);
//                         upstream holds the request while stall is high
//   req_op/addr/wdata     operation, byte address, right-aligned store data
//   stall                 pipeline hold
//   load_valid/load_data  one-cycle result pulse; data holds afterwards
//   misalign_err          misalignment pulse (trap build only)
//   mem_*                 data memory port (word-aligned byte address)
//   dbg_state             current FSM state
// Build option: define MAU_MISALIGN_TRAP_EN to trap misaligned requests
// instead of truncating the low address bits.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  op_t               req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              misalign_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_t            dbg_state
);

  state_t            state;
  op_t               cap_op;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_word;
  logic [15:0]       cap_wdata;
  logic [DATA_W-1:0] load_hold;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] merged_word;
  logic              accept;
  logic              trap;
  logic              go;

  // reset_n in the accept term keeps every strobe low while reset is held,
  // even if upstream keeps presenting a request.
  assign accept = (state == ST_IDLE) && req_valid && reset_n;

`ifdef MAU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_op, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign go           = accept && !trap;
  assign misalign_err = accept && trap;

  mau_lane_merge u_lane_merge (
    .op         (cap_op),
    .offset     (cap_addr[1:0]),
    .word       (cap_word),
    .wdata      (cap_wdata),
    .load_data  (ext_data),
    .store_word (merged_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cap_op    <= OP_LW;
      cap_addr  <= '0;
      cap_word  <= '0;
      cap_wdata <= '0;
      load_hold <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go && req_op != OP_SW) begin
            cap_op    <= req_op;
            cap_addr  <= req_addr;
            cap_word  <= mem_rdata;
            cap_wdata <= req_wdata[15:0];
            state     <= is_load(req_op) ? ST_LOAD_RESP : ST_STORE_MERGE;
          end
        end
        ST_LOAD_RESP: begin
          load_hold <= ext_data;
          state     <= ST_IDLE;
        end
        ST_STORE_MERGE: state <= ST_IDLE;
        default:        state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state  = state;
  assign req_ready  = (state == ST_IDLE);
  assign stall      = (state != ST_IDLE) || (req_valid && !req_ready);
  assign load_valid = (state == ST_LOAD_RESP);
  assign load_data  = load_valid ? ext_data : load_hold;

  // SW writes straight through in the accept cycle; every other accepted op
  // reads first. The merged subword write is issued from STORE_MERGE.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (go) begin
      mem_addr = {req_addr[ADDR_W-1:2], 2'b00};
      if (req_op == OP_SW) begin
        mem_write = 1'b1;
        mem_wdata = req_wdata;
      end else begin
        mem_read = 1'b1;
      end
    end else if (state == ST_STORE_MERGE) begin
      mem_write = 1'b1;
      mem_addr  = {cap_addr[ADDR_W-1:2], 2'b00};
      mem_wdata = merged_word;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit with a
// 64-word data memory and a word-array reference model.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  op_t         req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] dmem    [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_q[$];
  logic [31:0] last_load;

  typedef struct {
    logic        a_read, a_write, a_stall, a_mis, a_lv;
    logic [31:0] a_addr, a_wdata, a_ld;
    logic        b_read, b_write, b_stall, b_lv;
    logic [31:0] b_addr, b_wdata, b_ld;
  } obs_t;

  mem_access_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .misalign_err (misalign_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) dmem[mem_addr[7:2]] <= mem_wdata;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(op_t op, int a);
    int unsigned w, v;
    w = ref_mem[(a / 4) % 64];
    case (op)
      OP_LB, OP_LBU: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (op == OP_LB && v >= 128) v = v + 32'hFFFF_FF00;
      end
      OP_LH, OP_LHU: begin
        v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (op == OP_LH && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(op_t op, int a, int unsigned d);
    int unsigned w, sh, mask;
    w = ref_mem[(a / 4) % 64];
    case (op)
      OP_SB: begin sh = 8 * (a % 4);        mask = 32'hFF << sh; end
      OP_SH: begin sh = 16 * ((a / 2) % 2); mask = 32'hFFFF << sh; end
      default: begin sh = 0; mask = 32'hFFFF_FFFF; end
    endcase
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // ---------------- driver ----------------
  // Presents one request; for two-cycle ops keeps a random junk request
  // asserted during the busy cycle (it must be ignored).
  task automatic drive_op(input op_t op, input int a, input logic [31:0] d,
                          output obs_t o);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    @(negedge clk);
    o.a_read = mem_read; o.a_write = mem_write; o.a_stall = stall;
    o.a_mis = misalign_err; o.a_lv = load_valid; o.a_addr = mem_addr;
    o.a_wdata = mem_wdata; o.a_ld = load_data;
    o.b_read = 0; o.b_write = 0; o.b_stall = 0; o.b_lv = 0;
    o.b_addr = 0; o.b_wdata = 0; o.b_ld = 0;
    @(posedge clk); #1;
    if (op == OP_SW) begin
      req_valid = 1'b0;
    end else begin
      req_op = op_t'($urandom_range(0, 7)); req_addr = $urandom;
      req_wdata = $urandom;
      @(negedge clk);
      o.b_read = mem_read; o.b_write = mem_write; o.b_stall = stall;
      o.b_lv = load_valid; o.b_addr = mem_addr; o.b_wdata = mem_wdata;
      o.b_ld = load_data;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic idle_sample(output logic s, output logic lv,
                             output logic [31:0] ld);
    @(negedge clk); s = stall; lv = load_valid; ld = load_data;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_op = OP_LW; req_addr = 0;
    req_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, stall, load_valid, misalign_err, mem_read, mem_write} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got ready/stall/lv/mis/rd/wr=%b expected 100000",
               {req_ready, stall, load_valid, misalign_err, mem_read, mem_write});
    end
    n_checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || load_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h wdata=%h ld=%h expected all 0",
               mem_addr, mem_wdata, load_data);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_word();
    obs_t o; logic s, lv; logic [31:0] ld;
    dmem[0] = 32'd6; ref_mem[0] = 32'd6;
    drive_op(OP_LW, 32'h00, 32'h0, o);
    idle_sample(s, lv, ld);
    n_checks++;
    if (o.a_read !== 1'b1 || o.a_write !== 1'b0 || o.a_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL lw_strobe: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=0",
               o.a_read, o.a_write, o.a_addr);
    end
    n_checks++;
    if (o.b_lv !== 1'b1 || o.b_ld !== model_load(OP_LW, 0)) begin
      n_fail++;
      $display("FAIL lw_result: got lv=%b data=%h expected lv=1 data=%h",
               o.b_lv, o.b_ld, model_load(OP_LW, 0));
    end
    n_checks++;
    if ({o.a_stall, o.b_stall, s} !== 3'b010) begin
      n_fail++;
      $display("FAIL lw_stall: got %b expected 010", {o.a_stall, o.b_stall, s});
    end
    n_checks++;
    if (lv !== 1'b0 || ld !== 32'd6) begin
      n_fail++;
      $display("FAIL lw_hold: got lv=%b data=%h expected lv=0 data=00000006", lv, ld);
    end
    last_load = 32'd6;
  endtask

  task automatic test_subword_loads();
    obs_t o;
    op_t ops[3] = '{OP_LB, OP_LBU, OP_LHU};
    int  adr[3] = '{32'h15, 32'h15, 32'h16};
    logic [31:0] req[3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_FFFF};
    dmem[5] = 32'hFFFF_FFFF; ref_mem[5] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      drive_op(ops[i], adr[i], 32'h0, o);
      n_checks++;
      if (o.b_lv !== 1'b1 || o.b_ld !== req[i] || model_load(ops[i], adr[i]) !== req[i]) begin
        n_fail++;
        $display("FAIL subword_load_%0d: got lv=%b data=%h expected lv=1 data=%h",
                 i, o.b_lv, o.b_ld, req[i]);
      end
      last_load = req[i];
    end
    // Signed halfword with the upper lane selected.
    dmem[6] = 32'h8001_7FFF; ref_mem[6] = 32'h8001_7FFF;
    drive_op(OP_LH, 32'h1A, 32'h0, o);
    n_checks++;
    if (o.b_ld !== 32'hFFFF_8001) begin
      n_fail++;
      $display("FAIL lh_sign: got %h expected ffff8001", o.b_ld);
    end
    last_load = 32'hFFFF_8001;
  endtask

  task automatic test_subword_stores();
    obs_t o;
    dmem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;
    drive_op(OP_SB, 32'h22, 32'h0000_00AA, o);
    n_checks++;
    if (o.a_read !== 1'b1 || o.a_write !== 1'b0 || o.b_write !== 1'b1 ||
        o.b_read !== 1'b0 || o.b_wdata !== 32'h11AA_3344 || o.b_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL sb_merge: got rd=%b wr=%b/%b wdata=%h addr=%h expected 11aa3344 at 20",
               o.a_read, o.a_write, o.b_write, o.b_wdata, o.b_addr);
    end
    ref_mem[8] = model_store(OP_SB, 32'h22, 32'hAA);
    drive_op(OP_SH, 32'h20, 32'h0000_BEEF, o);
    n_checks++;
    if (o.b_write !== 1'b1 || o.b_wdata !== 32'h11AA_BEEF) begin
      n_fail++;
      $display("FAIL sh_merge: got wr=%b wdata=%h expected wr=1 wdata=11aabeef",
               o.b_write, o.b_wdata);
    end
    ref_mem[8] = model_store(OP_SH, 32'h20, 32'hBEEF);
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    drive_op(OP_SW, 32'h40, 32'h1234_5678, o1);
    drive_op(OP_LW, 32'h40, 32'h0, o2);
    ref_mem[16] = 32'h1234_5678;
    n_checks++;
    if (o1.a_write !== 1'b1 || o1.a_read !== 1'b0 || o1.a_stall !== 1'b0 ||
        o1.a_wdata !== 32'h1234_5678 || o1.a_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL sw_strobe: got wr=%b rd=%b stall=%b wdata=%h addr=%h expected 1 0 0 12345678 40",
               o1.a_write, o1.a_read, o1.a_stall, o1.a_wdata, o1.a_addr);
    end
    n_checks++;
    if (o2.b_lv !== 1'b1 || o2.b_ld !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL sw_then_lw: got lv=%b data=%h expected lv=1 data=12345678",
               o2.b_lv, o2.b_ld);
    end
    last_load = 32'h1234_5678;
  endtask

  task automatic test_misalign();
    obs_t o;
`ifdef MAU_MISALIGN_TRAP_EN
    logic mis, rd, lv;
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h41; req_wdata = 0;
    @(negedge clk);
    mis = misalign_err; rd = mem_read;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    lv = load_valid;
    n_checks++;
    if ({mis, rd, lv} !== 3'b100 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL misalign_trap: got mis/rd/lv=%b state=%0d expected 100 idle",
               {mis, rd, lv}, dbg_state);
    end
    @(posedge clk); #1;
`else
    drive_op(OP_LW, 32'h41, 32'h0, o);
    n_checks++;
    if (o.a_mis !== 1'b0 || o.a_addr !== 32'h40 || o.b_ld !== model_load(OP_LW, 32'h40)) begin
      n_fail++;
      $display("FAIL misalign_trunc: got mis=%b addr=%h data=%h expected 0 40 %h",
               o.a_mis, o.a_addr, o.b_ld, model_load(OP_LW, 32'h40));
    end
    last_load = model_load(OP_LW, 32'h40);
`endif
  endtask

  task automatic test_reset_abort();
    logic [31:0] old;
    old = 32'hCAFE_BABE; dmem[12] = old; ref_mem[12] = old;
    req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h31; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (dbg_state !== ST_STORE_MERGE) begin
      n_fail++;
      $display("FAIL abort_setup: got state=%0d expected %0d", dbg_state, ST_STORE_MERGE);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_write, mem_read, stall, load_valid, misalign_err} !== 5'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || load_data !== 32'h0 ||
        dbg_state !== ST_IDLE || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_outputs: got wr=%b rd=%b stall=%b addr=%h wdata=%h ld=%h state=%0d expected all 0 idle",
               mem_write, mem_read, stall, mem_addr, mem_wdata, load_data, dbg_state);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n_checks++;
    if (dmem[12] !== ref_mem[12]) begin
      n_fail++;
      $display("FAIL abort_nowrite: got %h expected %h", dmem[12], ref_mem[12]);
    end
    last_load = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    obs_t o; op_t op; int a; logic [31:0] d, e, aligned;
    for (int i = 0; i < 60; i++) begin
      op = op_t'($urandom_range(0, 7));
      a  = $urandom_range(0, 255);
      d  = $urandom;
`ifdef MAU_MISALIGN_TRAP_EN
      if (op == OP_LW || op == OP_SW) a = a - (a % 4);
      if (op == OP_LH || op == OP_LHU || op == OP_SH) a = a - (a % 2);
`endif
      aligned = a - (a % 4);
      if (is_load(op)) exp_q.push_back(model_load(op, a));
      else if (op != OP_SW) exp_q.push_back(model_store(op, a, d));
      drive_op(op, a, d, o);
      n_checks++;
      if (o.a_lv !== 1'b0 || o.a_ld !== last_load) begin
        n_fail++;
        $display("FAIL rnd_hold_%0d: got lv=%b data=%h expected lv=0 data=%h",
                 i, o.a_lv, o.a_ld, last_load);
      end
      n_checks++;
      if (o.a_addr !== aligned || o.a_read !== (op != OP_SW) || o.a_write !== (op == OP_SW)) begin
        n_fail++;
        $display("FAIL rnd_accept_%0d: got rd=%b wr=%b addr=%h expected addr %h op %0d",
                 i, o.a_read, o.a_write, o.a_addr, aligned, op);
      end
      if (op == OP_SW) begin
        ref_mem[aligned / 4] = d;
        n_checks++;
        if (o.a_wdata !== d) begin
          n_fail++;
          $display("FAIL rnd_sw_%0d: got %h expected %h", i, o.a_wdata, d);
        end
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (is_load(op)) begin
          last_load = e;
          if (o.b_lv !== 1'b1 || o.b_ld !== e || o.b_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_load_%0d: got lv=%b data=%h expected lv=1 data=%h op %0d",
                     i, o.b_lv, o.b_ld, e, op);
          end
        end else begin
          ref_mem[aligned / 4] = e;
          if (o.b_write !== 1'b1 || o.b_wdata !== e || o.b_addr !== aligned || o.b_lv !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_store_%0d: got wr=%b wdata=%h addr=%h expected wdata=%h addr=%h",
                     i, o.b_write, o.b_wdata, o.b_addr, e, aligned);
          end
        end
      end
    end
  endtask

  task automatic test_final_memory();
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (dmem[i] !== ref_mem[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL final_memory: got %0d differing words expected 0", bad);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int i = 0; i < 64; i++) begin dmem[i] = 32'h0; ref_mem[i] = 32'h0; end
    last_load = 32'h0;
    test_reset();
    test_load_word();
    test_subword_loads();
    test_subword_stores();
    test_back_to_back();
    test_misalign();
    test_reset_abort();
    test_random();
    test_final_memory();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
